// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - state encoding, default widths and clock constants for the pulse train generator
package pulse_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HIGH   = 2'd1,
      ST_LOW    = 2'd2,
      ST_FINISH = 2'd3
   } pg_state_t;

   localparam int DEF_WIDTH_W   = 16;
   localparam int DEF_COUNT_W   = 8;
   localparam int CLK_PERIOD_NS = 20;
   localparam int CYCLES_PER_US = 1000 / CLK_PERIOD_NS;

   // Rounds up so a requested duration is never shortened.
   function automatic int ns_to_cycles(input int ns);
      return (ns + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
   endfunction

endpackage

// File: rtl/down_timer.sv
// rtl/down_timer.sv - loadable down-counter with zero flag, shared by HIGH and LOW phase timing
module down_timer
   import pulse_gen_pkg::*;
#(
   parameter int WIDTH_W = DEF_WIDTH_W
) (
   input  logic               i_Clk,
   input  logic               i_Rst_L,
   input  logic               i_Load,
   input  logic [WIDTH_W-1:0] i_Value,
   output logic               o_Zero
);

   logic [WIDTH_W-1:0] r_count;

   // Parks at zero instead of wrapping so an idle timer stays quiet.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_count <= '0;
      end else if (i_Load) begin
         r_count <= i_Value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_Zero = (r_count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - burst of N configurable pulses with start/busy/done handshake and abort
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int   WIDTH_W    = DEF_WIDTH_W,
   parameter int   COUNT_W    = DEF_COUNT_W,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic               i_Clk,
   input  logic               i_Rst_L,
   input  logic               i_Start,
   input  logic               i_Abort,
   input  logic [WIDTH_W-1:0] i_Width,
   input  logic [WIDTH_W-1:0] i_Gap,
   input  logic [COUNT_W-1:0] i_Count,
   output logic               o_Pulse,
   output logic               o_Busy,
   output logic               o_Done,
   output logic               o_Aborted,
   output logic [COUNT_W-1:0] o_Pulse_Idx
);

   pg_state_t          r_state;
   pg_state_t          w_next;
   logic [WIDTH_W-1:0] r_width;
   logic [WIDTH_W-1:0] r_gap;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] r_idx;
   logic               r_pulse;
   logic               r_busy;
   logic               r_done;
   logic               r_aborted;
   logic               w_accept;
   logic               w_abort;
   logic               w_load;
   logic               w_zero;
   logic               w_last;
   logic               w_idx_inc;
   logic [WIDTH_W-1:0] w_load_val;

   // Timer reload for a phase of v cycles; a zero setting still lasts one cycle.
   function automatic logic [WIDTH_W-1:0] span_m1(input logic [WIDTH_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

   assign w_last = (r_idx == r_count - 1'b1);

   down_timer #(.WIDTH_W(WIDTH_W)) u_timer (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Load  (w_load),
      .i_Value (w_load_val),
      .o_Zero  (w_zero)
   );

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_abort    = 1'b0;
      w_load     = 1'b0;
      w_load_val = '0;
      w_idx_inc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_Start) begin
               w_accept = 1'b1;
               if (i_Count == '0) begin
                  w_next = ST_FINISH;
               end else begin
                  w_next     = ST_HIGH;
                  w_load     = 1'b1;
                  w_load_val = span_m1(i_Width);
               end
            end
         end
         ST_HIGH: begin
            if (i_Abort) begin
               w_abort = 1'b1;
               w_next  = ST_IDLE;
            end else if (w_zero) begin
               if (w_last) begin
                  w_next = ST_FINISH;
               end else begin
                  w_next     = ST_LOW;
                  w_load     = 1'b1;
                  w_load_val = span_m1(r_gap);
               end
            end
         end
         ST_LOW: begin
            if (i_Abort) begin
               w_abort = 1'b1;
               w_next  = ST_IDLE;
            end else if (w_zero) begin
               w_next     = ST_HIGH;
               w_load     = 1'b1;
               w_load_val = span_m1(r_width);
               w_idx_inc  = 1'b1;
            end
         end
         ST_FINISH: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_state   <= ST_IDLE;
         r_width   <= '0;
         r_gap     <= '0;
         r_count   <= '0;
         r_idx     <= '0;
         r_pulse   <= IDLE_LEVEL;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_width <= i_Width;
            r_gap   <= i_Gap;
            r_count <= i_Count;
            r_idx   <= '0;
         end else if (w_idx_inc) begin
            r_idx <= r_idx + 1'b1;
         end
         // Outputs follow the state being entered so they line up with it.
         r_pulse   <= (w_next == ST_HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
         r_busy    <= (w_next == ST_HIGH) || (w_next == ST_LOW);
         r_done    <= (w_next == ST_FINISH) || w_abort;
         r_aborted <= w_abort;
      end
   end

   assign o_Pulse     = r_pulse;
   assign o_Busy      = r_busy;
   assign o_Done      = r_done;
   assign o_Aborted   = r_aborted;
   assign o_Pulse_Idx = r_idx;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - scoreboard bench for pulse_train_gen at both idle polarities
module tb_pulse_train_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] width;
   logic [15:0] gap;
   logic [7:0]  count;

   logic       p0, b0, d0, a0;
   logic [7:0] x0;
   logic       p1, b1, d1, a1;
   logic [7:0] x1;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       pulse;
      logic       busy;
      logic       done;
      logic       aborted;
      logic [7:0] idx;
   } exp_t;

   exp_t exp_q[$];

   always #10 clk = ~clk;

   pulse_train_gen #(.WIDTH_W(16), .COUNT_W(8), .IDLE_LEVEL(1'b0)) dut0 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Abort(abort),
      .i_Width(width), .i_Gap(gap), .i_Count(count),
      .o_Pulse(p0), .o_Busy(b0), .o_Done(d0), .o_Aborted(a0), .o_Pulse_Idx(x0)
   );

   pulse_train_gen #(.WIDTH_W(16), .COUNT_W(8), .IDLE_LEVEL(1'b1)) dut1 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Abort(abort),
      .i_Width(width), .i_Gap(gap), .i_Count(count),
      .o_Pulse(p1), .o_Busy(b1), .o_Done(d1), .o_Aborted(a1), .o_Pulse_Idx(x1)
   );

   // Expected per-cycle outputs (active-high view) starting the cycle after the start edge.
   task automatic push_train(input int w, input int g, input int n, input int abort_at);
      exp_t seq[$];
      exp_t e;
      int   ew = (w == 0) ? 1 : w;
      int   eg = (g == 0) ? 1 : g;
      logic [7:0] last_idx;
      bit   ab = 1'b0;
      for (int p = 0; p < n; p++) begin
         for (int c = 0; c < ew; c++) begin
            e = '{pulse:1'b1, busy:1'b1, done:1'b0, aborted:1'b0, idx:8'(p)};
            seq.push_back(e);
         end
         if (p < n - 1) begin
            for (int c = 0; c < eg; c++) begin
               e = '{pulse:1'b0, busy:1'b1, done:1'b0, aborted:1'b0, idx:8'(p)};
               seq.push_back(e);
            end
         end
      end
      if (abort_at >= 0 && abort_at < seq.size()) begin
         ab = 1'b1;
         while (seq.size() > abort_at + 1) void'(seq.pop_back());
      end
      last_idx = (seq.size() == 0) ? 8'd0 : seq[seq.size()-1].idx;
      e = '{pulse:1'b0, busy:1'b0, done:1'b1, aborted:ab, idx:last_idx};
      seq.push_back(e);
      e = '{pulse:1'b0, busy:1'b0, done:1'b0, aborted:1'b0, idx:last_idx};
      seq.push_back(e);
      foreach (seq[i]) exp_q.push_back(seq[i]);
   endtask

   task automatic sb_cycle(input string tag, input int c);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s c%0d scoreboard empty", tag, c);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if ({p0, b0, d0, a0, x0} !== {e.pulse, e.busy, e.done, e.aborted, e.idx}) begin
         failures++;
         $display("FAIL %s c%0d lvl0 got p%b b%b d%b a%b i%0d need p%b b%b d%b a%b i%0d",
                  tag, c, p0, b0, d0, a0, x0, e.pulse, e.busy, e.done, e.aborted, e.idx);
      end
      checks++;
      if ({p1, b1, d1, a1, x1} !== {~e.pulse, e.busy, e.done, e.aborted, e.idx}) begin
         failures++;
         $display("FAIL %s c%0d lvl1 got p%b b%b d%b a%b i%0d need p%b b%b d%b a%b i%0d",
                  tag, c, p1, b1, d1, a1, x1, ~e.pulse, e.busy, e.done, e.aborted, e.idx);
      end
   endtask

   // Called at a negedge; leaves the bench at the negedge of the idle cycle after done.
   task automatic run_train(input string tag, input int w, input int g, input int n,
                            input int abort_at, input bit noise, input bit start_abort);
      int n_cyc;
      width = 16'(w);
      gap   = 16'(g);
      count = 8'(n);
      start = 1'b1;
      abort = start_abort;
      push_train(w, g, n, abort_at);
      n_cyc = exp_q.size();
      for (int c = 0; c < n_cyc; c++) begin
         @(negedge clk);
         sb_cycle(tag, c);
         start = 1'b0;
         abort = (c == abort_at);
         if (noise && c < n_cyc - 1) begin
            start = 1'b1;
            width = 16'($urandom_range(0, 40));
            gap   = 16'($urandom_range(0, 40));
            count = 8'($urandom_range(0, 9));
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s leftover got %0d need 0", tag, exp_q.size());
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      width = 16'd0;
      gap   = 16'd0;
      count = 8'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({p0, b0, d0, a0, x0} !== 12'h000) begin
         failures++;
         $display("FAIL reset_lvl0 got p%b b%b d%b a%b i%0d need all 0", p0, b0, d0, a0, x0);
      end
      checks++;
      if ({p1, b1, d1, a1, x1} !== {1'b1, 11'h000}) begin
         failures++;
         $display("FAIL reset_lvl1 got p%b b%b d%b a%b i%0d need p1 rest 0", p1, b1, d1, a1, x1);
      end
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_basic;
      run_train("basic", 4, 2, 3, -1, 1'b0, 1'b0);
   endtask

   task automatic test_zero_count;
      repeat (5) @(negedge clk);
      run_train("count0", 3, 3, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_zero_width_gap;
      run_train("wg0", 0, 0, 2, -1, 1'b0, 1'b0);
   endtask

   task automatic test_abort;
      run_train("abort", 8, 8, 5, 18, 1'b0, 1'b0);
   endtask

   task automatic test_idle_abort;
      abort = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if ({p0, b0, d0, a0} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_abort got p%b b%b d%b a%b need 0000", p0, b0, d0, a0);
         end
      end
      abort = 1'b0;
      run_train("start_abort", 2, 1, 2, -1, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back;
      run_train("busy_noise", 3, 2, 3, -1, 1'b1, 1'b0);
      run_train("restart", 2, 3, 2, -1, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset;
      width = 16'd2;
      gap   = 16'd1;
      count = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({p0, p1, x0} !== {1'b1, 1'b0, 8'd1}) begin
         failures++;
         $display("FAIL pre_reset got p0%b p1%b i%0d need p0 1 p1 0 i1", p0, p1, x0);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({p0, b0, d0, a0, x0, p1, b1, d1, a1, x1} !== {12'h000, 1'b1, 11'h000}) begin
         failures++;
         $display("FAIL async_reset got p0%b b%b d%b i%0d p1%b b%b i%0d need idle",
                  p0, b0, d0, x0, p1, b1, x1);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({p0, b0, d0, a0, d1, p1} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_hold got p0%b b%b d%b a%b d1%b p1%b need 000001",
                     p0, b0, d0, a0, d1, p1);
         end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({p0, b0, d0, d1} !== 4'b0000) begin
         failures++;
         $display("FAIL post_reset got p%b b%b d%b d1%b need 0000", p0, b0, d0, d1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_zero_width_gap();
      test_abort();
      test_idle_abort();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
